// File: rtl/instruction_queue_packer.sv
// instruction_queue_packer: packs sparse decoder slots into a circular queue
// and presents the oldest NUM_OUT entries to dispatch. Rev 1.0
`default_nettype none

module instruction_queue_packer #(
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 2,
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 128
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic [NUM_IN-1:0]              valid_i,
  input  logic [NUM_IN*PAYLOAD_W-1:0]    inst_i,
  output logic                           ready_o,
  output logic [NUM_OUT-1:0]             valid_o,
  output logic [NUM_OUT*PAYLOAD_W-1:0]   inst_o,
  input  logic [$clog2(NUM_OUT+1)-1:0]   deqCount_i,
  output logic [$clog2(DEPTH):0]         occupancy_o,
  output logic                           protoErr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PAYLOAD_W-1:0] storage_q [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;

  logic [CNT_W-1:0]     slot_off [NUM_IN];
  logic [CNT_W-1:0]     enq_n;
  logic [CNT_W-1:0]     avail;
  logic [CNT_W-1:0]     deq_req;
  logic [CNT_W-1:0]     deq_n;
  logic                 space_ok;
  logic                 any_valid;
  logic                 enq_fire;
  logic                 push_err;
  logic                 over_deq;

  // Each valid slot's destination offset is the number of valid slots below it.
  always_comb begin
    enq_n = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      slot_off[k] = enq_n;
      enq_n       = enq_n + CNT_W'(valid_i[k]);
    end
  end

  assign space_ok  = (count_q <= CNT_W'(DEPTH - NUM_IN));
  assign any_valid = |valid_i;
  assign enq_fire  = space_ok && any_valid;
  assign push_err  = !space_ok && any_valid;

  assign avail    = (count_q < CNT_W'(NUM_OUT)) ? count_q : CNT_W'(NUM_OUT);
  assign deq_req  = CNT_W'(deqCount_i);
  assign over_deq = (deq_req > avail);
  assign deq_n    = over_deq ? avail : deq_req;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + PTR_W'(enq_n);
      end
      head_d  = head_q + PTR_W'(deq_n);
      count_d = count_q + (enq_fire ? enq_n : '0) - deq_n;
      if (push_err || over_deq) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset; only entries inside [head, tail) are ever presented.
  always_ff @(posedge clock_i) begin
    if (reset_i && !flush_i && enq_fire) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (valid_i[k]) begin
          storage_q[tail_q + PTR_W'(slot_off[k])] <= inst_i[k*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  generate
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      assign valid_o[j]                       = reset_i && (CNT_W'(j) < avail);
      assign inst_o[j*PAYLOAD_W +: PAYLOAD_W] = storage_q[head_q + PTR_W'(j)];
    end
  endgenerate

  assign ready_o     = reset_i && space_ok;
  assign occupancy_o = count_q;
  assign protoErr_o  = err_q;

endmodule

`default_nettype wire
